// File: rtl/axis_frame_arbiter_if.sv
// AXI4-Stream interface shared by the arbiter, its requesters and the downstream FIFO.
interface AXIS_IF #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4,
    parameter int USER_W = 1
);
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [USER_W-1:0]   tuser;
    logic                twakeup;

    modport Master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
                    input  tready);
    modport Slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
                    output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one downstream AXIS FIFO, admitting a frame only when it fits.
// Optional macro AXIS_ARB_PRIORITY_EN gives port 0 strict priority over the round-robin ports.
module axis_frame_arbiter #(
    parameter int PORTS           = 4,
    parameter int FIFO_DEPTH      = 4096,
    parameter int MAX_FRAME_BEATS = 256,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int DEST_W          = 4,
    parameter int USER_W          = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    AXIS_IF.Slave                         in_axis_if [PORTS],
    AXIS_IF.Master                        out_axis_if,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_depth,
    output logic                          grant_valid,
    output logic [$clog2(PORTS)-1:0]      grant_index,
    output logic [31:0]                   frame_count
);
    localparam int GIDX_W  = $clog2(PORTS);
    localparam int DEPTH_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(FIFO_DEPTH);
    localparam logic [DEPTH_W-1:0] FRAME_MAX = DEPTH_W'(MAX_FRAME_BEATS);

    typedef struct packed {
        logic [DATA_W-1:0]   tdata;
        logic [DATA_W/8-1:0] tkeep;
        logic [DATA_W/8-1:0] tstrb;
        logic                tlast;
        logic [ID_W-1:0]     tid;
        logic [DEST_W-1:0]   tdest;
        logic [USER_W-1:0]   tuser;
        logic                twakeup;
    } beat_t;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [GIDX_W-1:0]   last_grant;
    logic [GIDX_W-1:0]   next_port;
    logic [GIDX_W-1:0]   cand;
    logic                next_found;
    logic                space_ok;
    logic                frame_done;
    logic [DEPTH_W-1:0]  fifo_free;
    logic [PORTS-1:0]    in_valid;
    logic [PORTS-1:0]    in_ready;
    beat_t               in_beat [PORTS];
    beat_t               out_beat;
    logic                out_valid;
    logic [1:0]          rst_sync;
    logic                rst_int_n;

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign in_valid[i] = in_axis_if[i].tvalid;
        assign in_beat[i]  = {in_axis_if[i].tdata, in_axis_if[i].tkeep, in_axis_if[i].tstrb,
                              in_axis_if[i].tlast, in_axis_if[i].tid, in_axis_if[i].tdest,
                              in_axis_if[i].tuser, in_axis_if[i].twakeup};
        assign in_axis_if[i].tready = in_ready[i];
    end

    // Reset asserts immediately but leaves the state registers only after two clean clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // Out-of-range depth readings wrap the subtraction, so they are rejected explicitly.
    assign fifo_free = DEPTH_MAX - fifo_depth;
    assign space_ok  = (fifo_depth <= DEPTH_MAX) && (fifo_free >= FRAME_MAX);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        next_port  = '0;
        next_found = 1'b0;
        cand       = '0;
`ifdef AXIS_ARB_PRIORITY_EN
        if (in_valid[0]) begin
            next_found = 1'b1;
        end else begin
            for (int k = 1; k < PORTS; k++) begin
                cand = GIDX_W'(1 + ((int'(last_grant) - 1 + k) % (PORTS - 1)));
                if (!next_found && in_valid[cand]) begin
                    next_found = 1'b1;
                    next_port  = cand;
                end
            end
        end
`else
        for (int k = 1; k <= PORTS; k++) begin
            cand = GIDX_W'((int'(last_grant) + k) % PORTS);
            if (!next_found && in_valid[cand]) begin
                next_found = 1'b1;
                next_port  = cand;
            end
        end
`endif
    end

    always_comb begin
        out_beat  = '0;
        out_valid = 1'b0;
        in_ready  = '0;
        if (grant_valid) begin
            out_beat              = in_beat[grant_index];
            out_valid             = in_valid[grant_index];
            in_ready[grant_index] = out_axis_if.tready;
        end
    end

    assign frame_done = out_valid && out_axis_if.tready && out_beat.tlast;

    assign out_axis_if.tvalid  = out_valid;
    assign out_axis_if.tdata   = out_beat.tdata;
    assign out_axis_if.tkeep   = out_beat.tkeep;
    assign out_axis_if.tstrb   = out_beat.tstrb;
    assign out_axis_if.tlast   = out_beat.tlast;
    assign out_axis_if.tid     = out_beat.tid;
    assign out_axis_if.tdest   = out_beat.tdest;
    assign out_axis_if.tuser   = out_beat.tuser;
    assign out_axis_if.twakeup = out_beat.twakeup;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            last_grant  <= GIDX_W'(PORTS - 1);
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_found && space_ok) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_index <= next_port;
                    end
                end
                GRANT: begin
                    if (frame_done) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        frame_count <= frame_count + 32'd1;
`ifdef AXIS_ARB_PRIORITY_EN
                        if (grant_index != '0) last_grant <= grant_index;
`else
                        last_grant  <= grant_index;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomised and directed bench for axis_frame_arbiter against a cycle-level behavioural model.
module tb_axis_frame_arbiter;
    localparam int PORTS           = 4;
    localparam int FIFO_DEPTH      = 4096;
    localparam int MAX_FRAME_BEATS = 256;

    logic              clk;
    logic              reset_n;
    logic [12:0]       fifo_depth;
    logic              grant_valid;
    logic [1:0]        grant_index;
    logic [31:0]       frame_count;
    logic              out_tready;
    logic [PORTS-1:0]  tv;
    logic [PORTS-1:0]  tready_obs;
    logic [50:0]       src_bus [PORTS];
    logic [50:0]       out_bus_obs;

    int                src_len  [PORTS];
    int                src_beat [PORTS];
    logic [31:0]       src_seq  [PORTS];
    int                prob     [PORTS];
    int                rdy_prob;
    int                fixed_len;
    bit                auto_mode;

    // Behavioural model of the arbiter.
    bit                m_busy;
    int                m_port;
    int                m_last;
    int                m_hold;
    logic [31:0]       m_count;

    int                n_cmp;
    int                n_bad;
    int                cyc;
    bit                gv_prev;
    int                grants [$];
    int                last_cyc [$];

    AXIS_IF in_if [PORTS] ();
    AXIS_IF out_if ();

    axis_frame_arbiter #(
        .PORTS(PORTS), .FIFO_DEPTH(FIFO_DEPTH), .MAX_FRAME_BEATS(MAX_FRAME_BEATS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_axis_if(in_if),
        .out_axis_if(out_if),
        .fifo_depth(fifo_depth),
        .grant_valid(grant_valid),
        .grant_index(grant_index),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            src_bus[i] = {4'(i), src_seq[i][27:0], src_seq[i][3:0], ~src_seq[i][3:0],
                          (src_beat[i] == src_len[i] - 1), 4'(i), 4'(src_len[i]),
                          1'(src_beat[i]), src_seq[i][0]};
        end
    end

    for (genvar i = 0; i < PORTS; i++) begin : g_src
        assign in_if[i].tvalid = tv[i];
        assign {in_if[i].tdata, in_if[i].tkeep, in_if[i].tstrb, in_if[i].tlast,
                in_if[i].tid, in_if[i].tdest, in_if[i].tuser, in_if[i].twakeup} = src_bus[i];
        assign tready_obs[i] = in_if[i].tready;
    end

    assign out_if.tready = out_tready;
    assign out_bus_obs = {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast,
                          out_if.tid, out_if.tdest, out_if.tuser, out_if.twakeup};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit space_ok_model();
        int fd = int'(fifo_depth);
        return (fd <= FIFO_DEPTH) && (FIFO_DEPTH - fd >= MAX_FRAME_BEATS);
    endfunction

    function automatic int pick();
`ifdef AXIS_ARB_PRIORITY_EN
        if (tv[0]) return 0;
        for (int d = 1; d < PORTS; d++) begin
            int p = 1 + (m_last - 1 + d) % (PORTS - 1);
            if (tv[p]) return p;
        end
`else
        for (int d = 1; d <= PORTS; d++) begin
            int p = (m_last + d) % PORTS;
            if (tv[p]) return p;
        end
`endif
        return 0;
    endfunction

    function automatic int new_len();
        return (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
    endfunction

    task automatic sample_and_check();
        logic [PORTS-1:0] er;
        er = '0;
        if (m_busy && out_tready) er[m_port] = 1'b1;
        check("grant_valid", grant_valid, m_busy);
        check("grant_index", grant_index, m_port);
        check("frame_count", frame_count, m_count);
        check("in_tready", tready_obs, er);
        check("out_tvalid", out_if.tvalid, m_busy && tv[m_port]);
        if (m_busy) check("out_bus", out_bus_obs, src_bus[m_port]);
        if (grant_valid && !gv_prev) grants.push_back(int'(grant_index));
        gv_prev = grant_valid;
        if (out_if.tvalid && out_tready && out_if.tlast) last_cyc.push_back(cyc);
    endtask

    task automatic advance();
        if (!reset_n) return;
        if (m_hold > 0) begin
            m_hold--;
        end else if (m_busy) begin
            if (tv[m_port] && out_tready) begin
                if (src_beat[m_port] == src_len[m_port] - 1) begin
                    src_beat[m_port] = 0;
                    src_len[m_port]  = new_len();
                    m_busy  = 1'b0;
                    m_count = m_count + 32'd1;
`ifdef AXIS_ARB_PRIORITY_EN
                    if (m_port != 0) m_last = m_port;
`else
                    m_last = m_port;
`endif
                end else begin
                    src_beat[m_port]++;
                end
                src_seq[m_port]++;
            end
        end else if (space_ok_model() && tv != '0) begin
            m_port = pick();
            m_busy = 1'b1;
        end
        if (auto_mode) begin
            int r;
            for (int p = 0; p < PORTS; p++) tv[p] = ($urandom_range(99) < prob[p]);
            out_tready = ($urandom_range(99) < rdy_prob);
            r = $urandom_range(99);
            if (r < 80)      fifo_depth = 13'($urandom_range(3840));
            else if (r < 95) fifo_depth = 13'($urandom_range(4096, 3841));
            else             fifo_depth = 13'($urandom_range(8191, 4097));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        sample_and_check();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        auto_mode  = 1'b0;
        tv         = '0;
        out_tready = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            src_beat[p] = 0;
            src_len[p]  = new_len();
        end
        m_busy  = 1'b0;
        m_port  = 0;
        m_last  = PORTS - 1;
        m_count = '0;
        m_hold  = 2;
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (2) cycle();
        grants.delete();
        last_cyc.delete();
    endtask

    initial begin
        logic [11:0] pat_rdy;
        logic [11:0] pat_v0;
        n_cmp = 0; n_bad = 0; cyc = 0; gv_prev = 1'b0;
        reset_n = 1'b1; tv = '0; out_tready = 1'b0; fifo_depth = '0;
        auto_mode = 1'b0; fixed_len = 3; rdy_prob = 100;
        for (int p = 0; p < PORTS; p++) begin
            src_seq[p] = 32'(p * 1000); src_beat[p] = 0; src_len[p] = 3; prob[p] = 0;
        end
        #3;

        // Reset state, then all four ports with back-to-back 3-beat frames.
        fixed_len = 3;
        do_reset();
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_out_tvalid", out_if.tvalid, 1'b0);
        tv = 4'b1111; out_tready = 1'b1; fifo_depth = '0;
        repeat (20) cycle();
        check("t1_frames", frame_count, 32'd5);
        check("t1_ngrants", grants.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < grants.size()) check("t1_order", grants[k], k % 4);
        for (int k = 1; k < last_cyc.size(); k++)
            check("t1_gap", last_cyc[k] - last_cyc[k-1], 4);

        // Single requester: two 4-beat frames with one bubble between them.
        fixed_len = 4;
        do_reset();
        tv = 4'b0100; out_tready = 1'b1;
        begin
            int c_first;
            c_first = cyc + 2;
            repeat (10) cycle();
            tv = '0;
            repeat (2) cycle();
            check("t2_ngrants", grants.size(), 2);
            for (int k = 0; k < grants.size(); k++) check("t2_index", grants[k], 2);
            check("t2_nlast", last_cyc.size(), 2);
            if (last_cyc.size() == 2) check("t2_span", last_cyc[1] - c_first + 1, 9);
            check("t2_frames", frame_count, 32'd2);
        end

        // Admission threshold on downstream free space, including illegal depths.
        fixed_len = 2;
        do_reset();
        tv = 4'b0010; out_tready = 1'b1; fifo_depth = 13'd3841;
        repeat (5) cycle();
        check("t3_nogrant", grant_valid, 1'b0);
        check("t3_noready", tready_obs, 4'b0000);
        fifo_depth = 13'd4097;
        repeat (3) cycle();
        fifo_depth = 13'h1FFF;
        repeat (2) cycle();
        check("t3_illegal", grant_valid, 1'b0);
        fifo_depth = 13'd3840;
        cycle();
        check("t3_grant", grant_valid, 1'b1);
        repeat (3) cycle();

        // Stalls on both sides mid-frame; port 3 waits for port 0's tlast.
        fixed_len = 5;
        fifo_depth = '0;
        do_reset();
        tv = 4'b1001; out_tready = 1'b1;
        cycle();
        pat_rdy = 12'b1111_1111_1101;
        pat_v0  = 12'b1111_1110_0111;
        for (int k = 0; k < 12; k++) begin
            out_tready = pat_rdy[k];
            tv[0]      = pat_v0[k];
            cycle();
        end
        check("t4_ngrants", grants.size(), 2);
        if (grants.size() >= 2) begin
            check("t4_first", grants[0], 0);
            check("t4_second", grants[1], 3);
        end
        check("t4_frames", frame_count, 32'd1);

        // Reset in the middle of a frame; port 0 wins first afterwards.
        fixed_len = 5;
        do_reset();
        tv = 4'b0010; out_tready = 1'b1;
        repeat (6) cycle();
        tv = 4'b0101;
        repeat (2) cycle();
        check("t5_mid_index", grant_index, 2'd2);
        check("t5_mid_count", frame_count, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_tvalid", out_if.tvalid, 1'b0);
        check("t5_async_grant", grant_valid, 1'b0);
        check("t5_async_count", frame_count, 32'd0);
        do_reset();
        tv = 4'b0101; out_tready = 1'b1;
        repeat (3) cycle();
        check("t5_ngrants", grants.size(), 1);
        if (grants.size() > 0) check("t5_first", grants[0], 0);

`ifdef AXIS_ARB_PRIORITY_EN
        // Port 0 strict priority.
        fixed_len = 2;
        do_reset();
        tv = 4'b0011; out_tready = 1'b1;
        repeat (9) cycle();
        tv = 4'b0010;
        repeat (3) cycle();
        tv = 4'b0011;
        repeat (3) cycle();
        check("tp_ngrants", grants.size(), 5);
        if (grants.size() == 5) begin
            check("tp_g0", grants[0], 0);
            check("tp_g1", grants[1], 0);
            check("tp_g2", grants[2], 0);
            check("tp_g3", grants[3], 1);
            check("tp_g4", grants[4], 0);
        end
`endif

        // Randomised traffic against the model.
        fixed_len = 0;
        do_reset();
        for (int p = 0; p < PORTS; p++) prob[p] = int'($urandom_range(100, 20));
        rdy_prob  = 70;
        auto_mode = 1'b1;
        repeat (4000) cycle();
        check("rand_frames_seen", (m_count > 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
